// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage of the five-stage MIPS core.
package mem_stage_pkg;

    localparam int WORD_BITS = 32;
    localparam int REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef enum logic [1:0] {
        MEM_ALU  = 2'd0,
        MEM_LOAD = 2'd1,
        MEM_NPC  = 2'd2,
        MEM_EXT  = 2'd3
    } memsel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } memstate_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM latch outputs, data-cache handshake and MEM/WB latch fields seen by the MEM stage.
interface mem_stage_if #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
);
    logic              exmem_valid;
    logic [WORD_W-1:0] alu_out;
    logic [WORD_W-1:0] rdat2;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] extout;
    logic              DRen;
    logic              DWen;
    logic              RegW;
    logic [1:0]        Mem;
    logic [REG_W-1:0]  dest;
    logic              halt;
    logic              memwb_flush;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              mem_stall;
    logic              wb_valid;
    logic              wb_RegW;
    logic              wb_halt;
    logic [REG_W-1:0]  wb_dest;
    logic [WORD_W-1:0] wb_data;
    logic              mem_misalign;
    logic              mem_timeout;

    // Pipeline/cache environment side.
    modport master (
        output exmem_valid, alu_out, rdat2, npc, extout, DRen, DWen, RegW, Mem, dest,
               halt, memwb_flush, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid, wb_RegW,
               wb_halt, wb_dest, wb_data, mem_misalign, mem_timeout
    );

    // MEM stage side.
    modport slave (
        input  exmem_valid, alu_out, rdat2, npc, extout, DRen, DWen, RegW, Mem, dest,
               halt, memwb_flush, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid, wb_RegW,
               wb_halt, wb_dest, wb_data, mem_misalign, mem_timeout
    );

endinterface

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline latch: writeback-data select plus bubble insertion on stall, flush or halt.
module memwb_reg
    import mem_stage_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              halted_i,
    input  logic              valid_i,
    input  logic              regw_i,
    input  logic              misalign_i,
    input  logic              halt_i,
    input  logic [REG_W-1:0]  dest_i,
    input  logic [1:0]        mem_i,
    input  logic [WORD_W-1:0] alu_i,
    input  logic [WORD_W-1:0] load_i,
    input  logic [WORD_W-1:0] npc_i,
    input  logic [WORD_W-1:0] ext_i,
    output logic              wb_valid_o,
    output logic              wb_regw_o,
    output logic              wb_halt_o,
    output logic [REG_W-1:0]  wb_dest_o,
    output logic [WORD_W-1:0] wb_data_o
);

    logic              valid_q, valid_d;
    logic              regw_q,  regw_d;
    logic              halt_q,  halt_d;
    logic [REG_W-1:0]  dest_q,  dest_d;
    logic [WORD_W-1:0] data_q,  data_d;
    logic [WORD_W-1:0] sel_data;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel_data = alu_i;
        case (memsel_t'(mem_i))
            MEM_LOAD: sel_data = load_i;
            MEM_NPC:  sel_data = npc_i;
            MEM_EXT:  sel_data = ext_i;
            default:  sel_data = alu_i;
        endcase
    end

    // A bubble clears the control fields; data and dest keep their last captured values.
    always_comb begin
        valid_d = 1'b0;
        regw_d  = 1'b0;
        halt_d  = 1'b0;
        dest_d  = dest_q;
        data_d  = data_q;
        if (!stall_i && !flush_i && !halted_i) begin
            valid_d = valid_i;
            regw_d  = regw_i & valid_i & ~misalign_i;
            halt_d  = halt_i & valid_i;
            dest_d  = dest_i;
            data_d  = sel_data;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values together.
        if (RST) begin
            valid_q <= 1'b0;
            regw_q  <= 1'b0;
            halt_q  <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            regw_q  <= regw_d;
            halt_q  <= halt_d;
            dest_q  <= dest_d;
            data_q  <= data_d;
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_regw_o  = regw_q;
    assign wb_halt_o  = halt_q;
    assign wb_dest_o  = dest_q;
    assign wb_data_o  = data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-cache request handshake, pipeline stall, halt tracking and sticky error flags.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic     CLK,
    input  logic     RST,
    mem_stage_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    memstate_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misalign_q, misalign_d;
    logic             timeout_q, timeout_d;

    logic access;
    logic aligned;
    logic memop;
    logic misalign;
    logic stall;

    assign access   = bus.exmem_valid & (bus.DRen | bus.DWen) & (state_q != HALTED);
    assign aligned  = (bus.alu_out[1:0] == 2'b00);
    assign memop    = access & aligned;
    assign misalign = access & ~aligned;
    assign stall    = memop & ~bus.dhit;

    // Requests follow the latched EX/MEM fields directly so a hit can complete in the first cycle.
    assign bus.dmemREN   = memop & bus.DRen & ~bus.DWen;
    assign bus.dmemWEN   = memop & bus.DWen;
    assign bus.dmemaddr  = bus.alu_out;
    assign bus.dmemstore = bus.rdat2;
    assign bus.mem_stall = stall;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        misalign_d = misalign_q | misalign;
        timeout_d  = timeout_q;
        case (state_q)
            IDLE: begin
                if (stall) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (bus.exmem_valid & bus.halt) begin
                    state_d = HALTED;
                end
            end
            WAIT: begin
                if (stall) begin
                    cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        // cnt_d counts stalled cycles and is zero whenever no access is waiting.
        if (cnt_d == CNT_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.mem_misalign = misalign_q;
    assign bus.mem_timeout  = timeout_q;

    memwb_reg #(
        .WORD_W (WORD_W),
        .REG_W  (REG_W)
    ) u_memwb (
        .CLK        (CLK),
        .RST        (RST),
        .stall_i    (stall),
        .flush_i    (bus.memwb_flush),
        .halted_i   (state_q == HALTED),
        .valid_i    (bus.exmem_valid),
        .regw_i     (bus.RegW),
        .misalign_i (misalign),
        .halt_i     (bus.halt),
        .dest_i     (bus.dest),
        .mem_i      (bus.Mem),
        .alu_i      (bus.alu_out),
        .load_i     (bus.dmemload),
        .npc_i      (bus.npc),
        .ext_i      (bus.extout),
        .wb_valid_o (bus.wb_valid),
        .wb_regw_o  (bus.wb_RegW),
        .wb_halt_o  (bus.wb_halt),
        .wb_dest_o  (bus.wb_dest),
        .wb_data_o  (bus.wb_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed table, multi-cycle corner cases and random traffic vs a model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TIMEOUT = 64;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_stage_if #(.WORD_W(32), .REG_W(5)) bus ();

    mem_stage #(.WORD_W(32), .REG_W(5), .TIMEOUT(TIMEOUT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic       valid, dren, dwen, regw, halt, flush, dhit;
        logic [1:0] mem;
        word_t      alu, rdat2, npc, ext, load;
        regbits_t   dest;
    } stim_t;

    typedef struct {
        string    name;
        stim_t    s;
        logic     ren, wen, stall, valid, regw, mis, chk;
        word_t    data;
        regbits_t dest;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state: what the MEM/WB latch and flags should hold.
    logic     m_halted, m_mis, m_to, m_wv, m_wr, m_wh;
    int       m_wait;
    word_t    m_wd;
    regbits_t m_dest;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s.valid = 0; s.dren = 0; s.dwen = 0; s.regw = 0; s.halt = 0; s.flush = 0; s.dhit = 0;
        s.mem = 2'd0; s.alu = '0; s.rdat2 = '0; s.npc = '0; s.ext = '0; s.load = '0; s.dest = '0;
        return s;
    endfunction

    function automatic stim_t mk(input logic v, rd, wr, rw, input logic [1:0] mem, input word_t alu,
                                 input word_t rdat2, input regbits_t dest, input logic fl, hit);
        stim_t s = nop();
        s.valid = v; s.dren = rd; s.dwen = wr; s.regw = rw; s.mem = mem; s.alu = alu;
        s.rdat2 = rdat2; s.dest = dest; s.flush = fl; s.dhit = hit;
        s.npc = 32'h40; s.ext = 32'hABCD0000; s.load = 32'h0BADC0DE;
        return s;
    endfunction

    function automatic vec_t mkv(input string n, input stim_t s, input logic ren, wen, stall, valid,
                                 regw, mis, chk, input word_t data, input regbits_t dest);
        vec_t v;
        v.name = n; v.s = s; v.ren = ren; v.wen = wen; v.stall = stall; v.valid = valid;
        v.regw = regw; v.mis = mis; v.chk = chk; v.data = data; v.dest = dest;
        return v;
    endfunction

    task automatic drive(input stim_t s);
        bus.exmem_valid = s.valid; bus.DRen = s.dren; bus.DWen = s.dwen; bus.RegW = s.regw;
        bus.halt = s.halt; bus.memwb_flush = s.flush; bus.dhit = s.dhit; bus.Mem = s.mem;
        bus.alu_out = s.alu; bus.rdat2 = s.rdat2; bus.npc = s.npc; bus.extout = s.ext;
        bus.dmemload = s.load; bus.dest = s.dest;
    endtask

    task automatic model_reset();
        m_halted = 0; m_mis = 0; m_to = 0; m_wv = 0; m_wr = 0; m_wh = 0;
        m_wait = 0; m_wd = '0; m_dest = '0;
    endtask

    function automatic logic m_access(input stim_t s);
        return s.valid && (s.dren || s.dwen) && !m_halted;
    endfunction

    function automatic logic m_aligned(input stim_t s);
        return (s.alu % 4) == 0;
    endfunction

    function automatic logic m_stall(input stim_t s);
        return m_access(s) && m_aligned(s) && !s.dhit;
    endfunction

    // One clock edge of the MEM stage expressed as the rules it must follow.
    task automatic model_step(input stim_t s);
        logic bad_align;
        bad_align = m_access(s) && !m_aligned(s);
        if (bad_align) m_mis = 1;
        if (m_stall(s)) begin
            m_wait = (m_wait < TIMEOUT) ? m_wait + 1 : TIMEOUT;
            if (m_wait == TIMEOUT) m_to = 1;
            m_wv = 0; m_wr = 0; m_wh = 0;
        end else begin
            m_wait = 0;
            if (m_halted || s.flush) begin
                m_wv = 0; m_wr = 0; m_wh = 0;
            end else begin
                m_wv   = s.valid;
                m_wr   = s.regw && s.valid && !bad_align;
                m_wh   = s.halt && s.valid;
                m_dest = s.dest;
                case (s.mem)
                    2'd1:    m_wd = s.load;
                    2'd2:    m_wd = s.npc;
                    2'd3:    m_wd = s.ext;
                    default: m_wd = s.alu;
                endcase
                if (s.valid && s.halt) m_halted = 1;
            end
        end
    endtask

    task automatic check_comb_model(input stim_t s, input string tag);
        logic req;
        req = m_access(s) && m_aligned(s);
        check({tag, "_ren"},   bus.dmemREN,   req && s.dren && !s.dwen);
        check({tag, "_wen"},   bus.dmemWEN,   req && s.dwen);
        check({tag, "_stall"}, bus.mem_stall, req && !s.dhit);
        check({tag, "_addr"},  bus.dmemaddr,  s.alu);
        check({tag, "_store"}, bus.dmemstore, s.rdat2);
    endtask

    task automatic check_regs_model(input string tag);
        check({tag, "_wb_valid"}, bus.wb_valid,     m_wv);
        check({tag, "_wb_regw"},  bus.wb_RegW,      m_wr);
        check({tag, "_wb_halt"},  bus.wb_halt,      m_wh);
        check({tag, "_wb_dest"},  bus.wb_dest,      m_dest);
        check({tag, "_wb_data"},  bus.wb_data,      m_wd);
        check({tag, "_misalign"}, bus.mem_misalign, m_mis);
        check({tag, "_timeout"},  bus.mem_timeout,  m_to);
    endtask

    task automatic half(input stim_t s);
        drive(s);
        @(negedge CLK);
    endtask

    task automatic finish_cycle(input stim_t s);
        @(posedge CLK);
        if (RST) model_reset();
        else     model_step(s);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(nop());
        repeat (2) @(posedge CLK);
        model_reset();
        #1;
        RST = 1'b0;
    endtask

    task automatic load_three_cycle();
        stim_t s = mk(1, 1, 0, 1, 2'd1, 32'h100, 32'h0, 5'd3, 0, 0);
        s.load = 32'hDEADBEEF;
        for (int c = 0; c < 3; c++) begin
            s.dhit = (c == 2);
            half(s);
            check("ld3_ren", bus.dmemREN, 1'b1);
            check("ld3_addr", bus.dmemaddr, 32'h100);
            check("ld3_stall", bus.mem_stall, c < 2);
            finish_cycle(s);
            if (c < 2) check("ld3_bubble", bus.wb_valid, 1'b0);
        end
        check("ld3_wb_data", bus.wb_data, 32'hDEADBEEF);
        check("ld3_wb_valid", bus.wb_valid, 1'b1);
        check("ld3_wb_regw", bus.wb_RegW, 1'b1);
        check("ld3_wb_dest", bus.wb_dest, 5'd3);
    endtask

    task automatic run_table();
        vec_t tbl[10];
        tbl[0] = mkv("st_zero_wait", mk(1,0,1,0,2'd0,32'h204,32'h12345678,5'd0,0,1), 0,1,0,1,0,0,1, 32'h204, 5'd0);
        tbl[1] = mkv("jal",          mk(1,0,0,1,2'd2,32'h1000,32'h0,5'd31,0,0),      0,0,0,1,1,0,1, 32'h40, 5'd31);
        tbl[2] = mkv("lui",          mk(1,0,0,1,2'd3,32'h2000,32'h0,5'd8,0,0),       0,0,0,1,1,0,1, 32'hABCD0000, 5'd8);
        tbl[3] = mkv("r0_write",     mk(1,0,0,1,2'd0,32'h55,32'h0,5'd0,0,0),         0,0,0,1,1,0,1, 32'h55, 5'd0);
        tbl[4] = mkv("rd_wr_both",   mk(1,1,1,0,2'd1,32'h208,32'hCAFEF00D,5'd9,0,1), 0,1,0,1,0,0,1, 32'h0BADC0DE, 5'd9);
        tbl[5] = mkv("flush",        mk(1,0,0,1,2'd0,32'h77,32'h0,5'd4,1,0),         0,0,0,0,0,0,0, 32'h0, 5'd0);
        tbl[6] = mkv("invalid_ld",   mk(0,1,0,1,2'd0,32'h300,32'h0,5'd4,0,0),        0,0,0,0,0,0,0, 32'h0, 5'd0);
        tbl[7] = mkv("misalign_ld",  mk(1,1,0,1,2'd1,32'h102,32'h0,5'd5,0,0),        0,0,0,1,0,1,0, 32'h0, 5'd0);
        tbl[8] = mkv("mis_sticky",   mk(1,0,0,1,2'd0,32'h10,32'h0,5'd2,0,1),         0,0,0,1,1,1,1, 32'h10, 5'd2);
        tbl[9] = mkv("misalign_st",  mk(1,0,1,1,2'd0,32'h203,32'h1,5'd3,0,1),        0,0,0,1,0,1,0, 32'h0, 5'd0);
        foreach (tbl[i]) begin
            half(tbl[i].s);
            check({tbl[i].name, "_ren"},   bus.dmemREN,   tbl[i].ren);
            check({tbl[i].name, "_wen"},   bus.dmemWEN,   tbl[i].wen);
            check({tbl[i].name, "_stall"}, bus.mem_stall, tbl[i].stall);
            check({tbl[i].name, "_store"}, bus.dmemstore, tbl[i].s.rdat2);
            finish_cycle(tbl[i].s);
            check({tbl[i].name, "_wb_valid"}, bus.wb_valid,     tbl[i].valid);
            check({tbl[i].name, "_wb_regw"},  bus.wb_RegW,      tbl[i].regw);
            check({tbl[i].name, "_misalign"}, bus.mem_misalign, tbl[i].mis);
            if (tbl[i].chk) begin
                check({tbl[i].name, "_wb_data"}, bus.wb_data, tbl[i].data);
                check({tbl[i].name, "_wb_dest"}, bus.wb_dest, tbl[i].dest);
            end
        end
    endtask

    task automatic flush_during_stall();
        stim_t s = mk(1, 1, 0, 1, 2'd1, 32'h110, 32'h0, 5'd4, 1, 0);
        s.load = 32'h11112222;
        for (int c = 0; c < 3; c++) begin
            s.dhit  = (c == 2);
            s.flush = (c < 2);
            half(s);
            check("fls_ren", bus.dmemREN, 1'b1);
            check("fls_stall", bus.mem_stall, c < 2);
            finish_cycle(s);
        end
        check("fls_wb_valid", bus.wb_valid, 1'b1);
        check("fls_wb_data", bus.wb_data, 32'h11112222);
    endtask

    task automatic run_random(input int n);
        stim_t s;
        int    kind;
        int    w;
        logic  stalled;
        for (int i = 0; i < n; i++) begin
            s = nop();
            s.valid = ($urandom_range(0, 7) != 0);
            kind    = $urandom_range(0, 3);
            s.dren  = (kind == 1) || (kind == 3);
            s.dwen  = (kind >= 2);
            s.alu   = $urandom;
            if ($urandom_range(0, 7) != 0) s.alu[1:0] = 2'b00;
            s.rdat2 = $urandom; s.npc = $urandom; s.ext = $urandom;
            s.regw  = 1'($urandom_range(0, 1));
            s.mem   = 2'($urandom_range(0, 3));
            s.dest  = 5'($urandom_range(0, 31));
            w = 0;
            do begin
                s.dhit  = (w >= 8) || ($urandom_range(0, 2) == 0);
                s.flush = ($urandom_range(0, 9) == 0);
                s.load  = $urandom;
                half(s);
                check_comb_model(s, "rnd");
                stalled = m_stall(s);
                finish_cycle(s);
                check_regs_model("rnd");
                w++;
            end while (stalled && w < 20);
        end
    endtask

    task automatic timeout_test();
        stim_t s = mk(1, 1, 0, 1, 2'd1, 32'h120, 32'h0, 5'd6, 0, 0);
        s.load = 32'h5A5A5A5A;
        for (int k = 1; k <= 70; k++) begin
            half(s);
            if (k == 70) check("to_stall70", bus.mem_stall, 1'b1);
            finish_cycle(s);
            if (k == 63) check("to_before", bus.mem_timeout, 1'b0);
            if (k == 64) check("to_at_limit", bus.mem_timeout, 1'b1);
        end
        s.dhit = 1;
        half(s);
        check("to_stall_drop", bus.mem_stall, 1'b0);
        finish_cycle(s);
        check("to_wb_data", bus.wb_data, 32'h5A5A5A5A);
        check("to_wb_valid", bus.wb_valid, 1'b1);
        check("to_sticky", bus.mem_timeout, 1'b1);
    endtask

    task automatic halt_test();
        stim_t s = mk(1, 1, 0, 1, 2'd1, 32'h140, 32'h0, 5'd7, 0, 0);
        for (int c = 0; c < 2; c++) begin
            s.dhit = (c == 1);
            half(s);
            finish_cycle(s);
        end
        check("hlt_ld_valid", bus.wb_valid, 1'b1);
        check("hlt_ld_halt", bus.wb_halt, 1'b0);
        s = mk(1, 0, 0, 0, 2'd0, 32'h0, 32'h0, 5'd0, 0, 0);
        s.halt = 1;
        half(s);
        check("hlt_no_stall", bus.mem_stall, 1'b0);
        finish_cycle(s);
        check("hlt_wb_halt", bus.wb_halt, 1'b1);
        check("hlt_wb_valid", bus.wb_valid, 1'b1);
        s = mk(1, 1, 0, 1, 2'd1, 32'h100, 32'h0, 5'd1, 0, 0);
        for (int c = 0; c < 2; c++) begin
            half(s);
            check("hltd_ren", bus.dmemREN, 1'b0);
            check("hltd_stall", bus.mem_stall, 1'b0);
            finish_cycle(s);
            check("hltd_wb_valid", bus.wb_valid, 1'b0);
            check("hltd_wb_halt", bus.wb_halt, 1'b0);
        end
    endtask

    task automatic rst_mid_wait_test();
        stim_t s = mk(1, 1, 0, 1, 2'd1, 32'h180, 32'h0, 5'd10, 0, 0);
        s.load = 32'h0F0F0F0F;
        for (int k = 0; k < 66; k++) begin
            half(s);
            finish_cycle(s);
        end
        check("rstw_timeout_set", bus.mem_timeout, 1'b1);
        drive(s);
        RST = 1'b1;
        @(posedge CLK);
        model_reset();
        #1;
        RST = 1'b0;
        drive(nop());
        @(negedge CLK);
        check("rstw_ren", bus.dmemREN, 1'b0);
        check("rstw_stall", bus.mem_stall, 1'b0);
        check("rstw_timeout", bus.mem_timeout, 1'b0);
        check("rstw_misalign", bus.mem_misalign, 1'b0);
        check("rstw_wb_valid", bus.wb_valid, 1'b0);
        check("rstw_wb_regw", bus.wb_RegW, 1'b0);
        check("rstw_wb_halt", bus.wb_halt, 1'b0);
        check("rstw_wb_data", bus.wb_data, 32'h0);
        check("rstw_wb_dest", bus.wb_dest, 5'd0);
        s.dhit = 1;
        half(s);
        check("rstw_zero_wait", bus.mem_stall, 1'b0);
        finish_cycle(s);
        check("rstw_wb_data2", bus.wb_data, 32'h0F0F0F0F);
    endtask

    initial begin
        drive(nop());
        do_reset();
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_wb_regw", bus.wb_RegW, 1'b0);
        check("rst_wb_halt", bus.wb_halt, 1'b0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        check("rst_wb_dest", bus.wb_dest, 5'd0);
        check("rst_misalign", bus.mem_misalign, 1'b0);
        check("rst_timeout", bus.mem_timeout, 1'b0);
        check("rst_stall", bus.mem_stall, 1'b0);

        load_three_cycle();
        run_table();
        flush_during_stall();
        run_random(300);
        do_reset();
        timeout_test();
        halt_test();
        do_reset();
        rst_mid_wait_test();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
